dmem_responder: RTL and testbench



---
 rtl/dmem_responder.sv | 151 +++++++++++++++
 tb/tb_dmem_responder.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request, WAIT_CYCLES wait states, byte-masked
// store or full-word load, one-cycle response. Optional macro: DMEM_MISALIGN_CHECK_EN.

module dmem_lane #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] idx,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);
  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[idx] <= wdata;

  assign rdata = mem[idx];
endmodule

module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_amp,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);
  localparam int NUM_LANES = 4;
  localparam int AW        = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    logic                      we;
    logic [31:0]               addr;
    logic [NUM_LANES-1:0]      amp;
    logic [NUM_LANES-1:0][7:0] wdata;
  } req_t;

  state_t state;
  logic [3:0] cnt;
  req_t in_req, cap, acc;
  logic do_access, range_ok, amp_bad, err;
  logic [NUM_LANES-1:0]      lane_we;
  logic [NUM_LANES-1:0][7:0] lane_rd;
  logic [31:0] rd_word;

  assign in_req = '{we: req_we, addr: req_addr, amp: req_amp, wdata: req_wdata};

  // With no wait states the access shares the accept edge, so the request
  // is taken straight from the port on that one edge.
  assign acc = (WAIT_CYCLES == 0) ? in_req : cap;

  assign do_access = (state == WAIT && cnt == 4'd0) ||
                     (WAIT_CYCLES == 0 && state == IDLE && req_valid);

  assign range_ok = (acc.addr[31:AW+2] == '0);

`ifdef DMEM_MISALIGN_CHECK_EN
  always_comb begin
    amp_bad = 1'b1;
    case (acc.amp)
      4'b0000: amp_bad = 1'b0;
      4'b1111: amp_bad = (acc.addr[1:0] != 2'd0);
      4'b0011: amp_bad = (acc.addr[1:0] != 2'd0);
      4'b1100: amp_bad = (acc.addr[1:0] != 2'd2);
      4'b0001: amp_bad = (acc.addr[1:0] != 2'd0);
      4'b0010: amp_bad = (acc.addr[1:0] != 2'd1);
      4'b0100: amp_bad = (acc.addr[1:0] != 2'd2);
      4'b1000: amp_bad = (acc.addr[1:0] != 2'd3);
      default: amp_bad = 1'b1;
    endcase
  end
`else
  logic unused_lo;
  assign unused_lo = ^acc.addr[1:0];
  assign amp_bad   = 1'b0;
`endif

  assign err = !range_ok || amp_bad;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign lane_we[i] = do_access && acc.we && !err && acc.amp[i];
    dmem_lane #(.DEPTH(DEPTH_WORDS), .AW(AW)) u_lane (
      .clk   (clk),
      .we    (lane_we[i]),
      .idx   (acc.addr[AW+1:2]),
      .wdata (acc.wdata[i]),
      .rdata (lane_rd[i])
    );
  end

  assign rd_word = (acc.we || err) ? 32'd0 : lane_rd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      cap       <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          cap       <= in_req;
          req_ready <= 1'b0;
          busy      <= 1'b1;
          if (WAIT_CYCLES == 0) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= rd_word;
            rsp_err   <= err;
          end else begin
            state <= WAIT;
            cnt   <= CNT_INIT;
          end
        end
        WAIT: if (cnt == 4'd0) begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_rdata <= rd_word;
          rsp_err   <= err;
        end else begin
          cnt <= cnt - 4'd1;
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with a response scoreboard; honours
// DMEM_MISALIGN_CHECK_EN when defined.

module tb_dmem_responder;
  localparam int DEPTH_WORDS = 1024;
  localparam int WAIT_CYCLES = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_amp;
  logic        rsp_valid, rsp_err, busy;
  logic [31:0] rsp_rdata;

  int tests = 0;
  int fails = 0;
  logic [32:0] exp_q [$];

  dmem_responder #(.DEPTH_WORDS(DEPTH_WORDS), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_amp(req_amp), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every response must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        chk("rsp_rdata", rsp_rdata, e[31:0]);
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, e[32]});
      end
    end
  end

  task automatic xact(input logic we, input logic [31:0] addr, input logic [3:0] amp,
                      input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_err);
    int n;
    exp_q.push_back({exp_err, exp_rd});
    @(negedge clk);
    req_we = we; req_addr = addr; req_amp = amp; req_wdata = wdata; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 32) begin @(negedge clk); n++; end
    chk("accept_timeout", 32'(n >= 32), 32'd0);
    @(posedge clk); #1;
    // Scramble the inputs: nothing after the accept edge may matter.
    req_valid = 1'b0; req_we = ~we; req_addr = $urandom; req_amp = 4'hF; req_wdata = $urandom;
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 64);
    chk("latency", 32'(n), 32'(WAIT_CYCLES + 1));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0;
    req_addr = '0; req_amp = '0; req_wdata = '0;
    #12;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk); reset = 1'b0;

    // Word store/load
    xact(1'b1, 32'h10, 4'b1111, 32'hDEADBEEF, 32'h0, 1'b0);
    xact(1'b0, 32'h10, 4'b1111, 32'h0, 32'hDEADBEEF, 1'b0);
    // Response data holds after the strobe
    @(negedge clk);
    chk("rdata_hold", rsp_rdata, 32'hDEADBEEF);
    // Byte and halfword stores
    xact(1'b1, 32'h12, 4'b0100, 32'h00AA0000, 32'h0, 1'b0);
    xact(1'b0, 32'h10, 4'b1111, 32'h0, 32'hDEAABEEF, 1'b0);
    xact(1'b1, 32'h12, 4'b1100, 32'h12340000, 32'h0, 1'b0);
    xact(1'b0, 32'h10, 4'b1111, 32'h0, 32'h1234BEEF, 1'b0);
    // amp=0 store: ack only
    xact(1'b1, 32'h10, 4'b0000, 32'hFFFFFFFF, 32'h0, 1'b0);
    // Load returns the full word whatever amp says
    xact(1'b0, 32'h10, 4'b0001, 32'h0, 32'h1234BEEF, 1'b0);

    // Range: last word works, first word past the end errors without writing
    xact(1'b1, 32'h0, 4'b1111, 32'h0BADC0DE, 32'h0, 1'b0);
    xact(1'b1, 32'hFFC, 4'b1111, 32'h55AA55AA, 32'h0, 1'b0);
    xact(1'b0, 32'hFFC, 4'b1111, 32'h0, 32'h55AA55AA, 1'b0);
    xact(1'b1, 32'h1000, 4'b1111, 32'hCAFEF00D, 32'h0, 1'b1);
    xact(1'b0, 32'h1000, 4'b1111, 32'h0, 32'h0, 1'b1);
    xact(1'b0, 32'h0, 4'b1111, 32'h0, 32'h0BADC0DE, 1'b0);

    // Back-to-back loads with req_valid held high
    exp_q.push_back({1'b0, 32'h1234BEEF});
    exp_q.push_back({1'b0, 32'h55AA55AA});
    @(negedge clk);
    req_we = 1'b0; req_addr = 32'h10; req_amp = 4'hF; req_valid = 1'b1;
    chk("b2b_ready_idle", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_addr = 32'hFFC;
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready && n < 32);
    chk("b2b_gap", 32'(n), 32'(WAIT_CYCLES + 2));
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 64);
    chk("b2b_latency", 32'(n), 32'(WAIT_CYCLES + 1));

    // Reset during the wait states of a store
    xact(1'b1, 32'h20, 4'b1111, 32'h11223344, 32'h0, 1'b0);
    @(negedge clk);
    req_we = 1'b1; req_addr = 32'h20; req_amp = 4'hF; req_wdata = 32'hFFFFFFFF; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("wait_busy", {31'd0, busy}, 32'd1);
    chk("wait_ready", {31'd0, req_ready}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
    for (int k = 0; k < 2 * WAIT_CYCLES + 4; k++) begin
      @(negedge clk);
      chk("post_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    xact(1'b0, 32'h20, 4'b1111, 32'h0, 32'h11223344, 1'b0);

`ifdef DMEM_MISALIGN_CHECK_EN
    xact(1'b1, 32'h11, 4'b1111, 32'h99999999, 32'h0, 1'b1);
    xact(1'b0, 32'h10, 4'b1111, 32'h0, 32'h1234BEEF, 1'b0);
    xact(1'b1, 32'h11, 4'b0010, 32'h00007700, 32'h0, 1'b0);
    xact(1'b0, 32'h10, 4'b1111, 32'h0, 32'h123477EF, 1'b0);
`else
    xact(1'b1, 32'h11, 4'b1111, 32'h99999999, 32'h0, 1'b0);
    xact(1'b0, 32'h10, 4'b1111, 32'h0, 32'h99999999, 1'b0);
`endif

    repeat (4) @(negedge clk);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
